// File: rtl/pb_bus_pkg.sv
// Shared types and constants for the parallel board bus cycle controller.
package pb_bus_pkg;

  localparam int PB_ADDR_W = 3;
  localparam int PB_DATA_W = 8;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } pb_state_t;

  typedef struct packed {
    logic                 write;
    logic [PB_ADDR_W-1:0] address;
    logic                 test_address;
    logic [PB_DATA_W-1:0] data;
  } pb_cmd_t;

  function automatic int unsigned pb_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_phase_timer.sv
// Loadable down-counter shared by all bus phases; done is high while the count is zero.
module pb_phase_timer #(
  parameter int unsigned     W           = 4,
  parameter logic [W-1:0]    RESET_VALUE = '0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         count_en,
  output logic         done
);

  logic [W-1:0] count;

  // Resetting to RESET_VALUE lets the board-reset phase start timing on the first clock after release.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pb_cycle_controller.sv
// Parallel board bus cycle controller: board-reset sequence, then one timed read/write access per command.
// Optional macro PB_WAIT_EN adds the bus_wait input that stretches the strobe up to WAIT_TIMEOUT clocks.
//
// Handshake: a command is taken at any edge where cmd_valid && cmd_ready; cmd_ready is only high in IDLE.
// rsp_valid is a single-cycle pulse with no backpressure; rsp_data/rsp_error are meaningful only with it.
module pb_cycle_controller
  import pb_bus_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 100,
  parameter int unsigned SETUP_CYCLES  = 3,
  parameter int unsigned STROBE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 3,
  parameter int unsigned WAIT_TIMEOUT  = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [PB_ADDR_W-1:0] cmd_address,
  input  logic                 cmd_test_address,
  input  logic [PB_DATA_W-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [PB_DATA_W-1:0] rsp_data,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [PB_DATA_W-1:0] data_out,
  output logic                 data_oe,
  input  logic [PB_DATA_W-1:0] data_in,
  output logic [PB_ADDR_W-1:0] address_out,
  output logic                 test_address_out,
  output logic                 b0_out,
  output logic                 rd_out,
  output logic                 wr_out,
  output logic                 reset_out,
  output pb_state_t            state
`ifdef PB_WAIT_EN
  ,
  input  logic                 bus_wait
`endif
);

  localparam int unsigned MAX_CYCLES =
    pb_max(pb_max(RESET_CYCLES, SETUP_CYCLES), pb_max(STROBE_CYCLES, HOLD_CYCLES));
  localparam int unsigned TW = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] RESET_LOAD  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] SETUP_LOAD  = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] STROBE_LOAD = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);

  pb_cmd_t              cmd_q;
  logic [PB_DATA_W-1:0] read_q;
  logic                 accept;
  logic                 strobe_end;
  logic                 timer_load;
  logic [TW-1:0]        timer_value;
  logic                 timer_en;
  logic                 timer_done;

  assign accept           = cmd_valid && cmd_ready;
  assign address_out      = cmd_q.address;
  assign test_address_out = cmd_q.test_address;
  assign data_out         = cmd_q.data;

`ifdef PB_WAIT_EN
  localparam int unsigned    WW         = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WW-1:0]  WAIT_LIMIT = WW'(WAIT_TIMEOUT);

  logic [WW-1:0] wait_cnt;
  logic          wait_more;
  logic          timed_out;
  logic          error_q;

  // The strobe is stretched only once its nominal length has elapsed.
  assign wait_more  = bus_wait && (wait_cnt != WAIT_LIMIT);
  assign timed_out  = bus_wait && (wait_cnt == WAIT_LIMIT);
  assign strobe_end = timer_done && !wait_more;
`else
  assign strobe_end = timer_done;
  assign rsp_error  = 1'b0;
`endif

  pb_phase_timer #(
    .W           (TW),
    .RESET_VALUE (RESET_LOAD)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .count_en   (timer_en),
    .done       (timer_done)
  );

  // Each phase loads N-1 on entry and leaves on the edge where the count is already zero.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    timer_en    = 1'b0;
    case (state)
      INIT: timer_en = !timer_done;
      IDLE: begin
        if (accept) begin
          timer_load  = 1'b1;
          timer_value = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (timer_done) begin
          timer_load  = 1'b1;
          timer_value = STROBE_LOAD;
        end else begin
          timer_en = 1'b1;
        end
      end
      STROBE: begin
        if (strobe_end) begin
          timer_load  = 1'b1;
          timer_value = HOLD_LOAD;
        end else begin
          timer_en = !timer_done;
        end
      end
      HOLD:    timer_en = !timer_done;
      default: timer_en = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= INIT;
      reset_out <= 1'b1;
      b0_out    <= 1'b0;
      rd_out    <= 1'b0;
      wr_out    <= 1'b0;
      data_oe   <= 1'b0;
      cmd_q     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b1;
      read_q    <= '0;
`ifdef PB_WAIT_EN
      wait_cnt  <= '0;
      error_q   <= 1'b0;
      rsp_error <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        INIT: begin
          if (timer_done) begin
            state     <= IDLE;
            reset_out <= 1'b0;
            b0_out    <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        IDLE: begin
          if (accept) begin
            cmd_q.write        <= cmd_write;
            cmd_q.address      <= cmd_address;
            cmd_q.test_address <= cmd_test_address;
            // Reads leave the previous drive value in place; only the enable matters.
            if (cmd_write) begin
              cmd_q.data <= cmd_data;
              data_oe    <= 1'b1;
            end
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (timer_done) begin
            rd_out <= !cmd_q.write;
            wr_out <= cmd_q.write;
            state  <= STROBE;
`ifdef PB_WAIT_EN
            wait_cnt <= '0;
`endif
          end
        end
        STROBE: begin
          if (strobe_end) begin
            rd_out <= 1'b0;
            wr_out <= 1'b0;
            read_q <= cmd_q.write ? '0 : data_in;
            state  <= HOLD;
`ifdef PB_WAIT_EN
            error_q <= timed_out;
`endif
          end
`ifdef PB_WAIT_EN
          else if (timer_done) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (timer_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= read_q;
            data_oe   <= 1'b0;
            state     <= RESP;
`ifdef PB_WAIT_EN
            rsp_error <= error_q;
`endif
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
